// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives one-outstanding instruction-memory reads from
// the PC and registers the fetched word into the IF/ID pipeline register.
// A one-entry skid buffer catches an access that completes while decode stalls.
// Optional feature macro: MISALIGN_TRAP_EN (a misaligned redirect enters TRAP
// and raises fetch_misaligned). Without it, redirect targets are word-aligned.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam logic [31:0] NOP = 32'h00000013;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, TRAP} state_t;
`else
  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        redirect_allowed;
  logic [31:0] redirect_pc;
  logic        redirect_trap;
  logic        complete;

`ifdef MISALIGN_TRAP_EN
  // Once trapped, only reset gets the stage going again.
  assign redirect_allowed = (state_q != TRAP);
  assign redirect_pc      = branch_target;
  assign redirect_trap    = (branch_target[1:0] != 2'b00);
  assign fetch_misaligned = (state_q == TRAP);
`else
  assign redirect_allowed = 1'b1;
  assign redirect_pc      = branch_target & 32'hFFFF_FFFC;
  assign redirect_trap    = 1'b0;
`endif

  // A request is only ever open in FETCH, so imem_ready alone marks completion there.
  assign imem_req          = (state_q == FETCH);
  assign imem_addr         = pc_q;
  assign complete          = imem_req && imem_ready;
  assign if_id_instruction = instr_q;
  assign if_id_pc          = id_pc_q;
  assign if_id_pc_plus4    = id_pc_q + 32'd4;
  assign if_id_valid       = valid_q;

  // Next-state logic: redirect overrides stall and any completing access.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    id_pc_d      = id_pc_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (branch_taken && redirect_allowed) begin
      pc_d         = redirect_pc;
      instr_d      = NOP;
      valid_d      = 1'b0;
      skid_instr_d = NOP;
      skid_pc_d    = 32'h0;
`ifdef MISALIGN_TRAP_EN
      state_d      = redirect_trap ? TRAP : FETCH;
`else
      state_d      = FETCH;
`endif
    end else begin
      case (state_q)
        BOOT: state_d = FETCH;
        FETCH: begin
          if (complete && !stall) begin
            instr_d = imem_rdata;
            id_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end else if (complete) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            pc_d         = pc_q + 32'd4;
            state_d      = HOLD;
          end else if (!stall) begin
            instr_d = NOP;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d = skid_instr_q;
            id_pc_d = skid_pc_q;
            valid_d = 1'b1;
            state_d = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      instr_q      <= NOP;
      id_pc_q      <= 32'h0;
      valid_q      <= 1'b0;
      skid_instr_q <= NOP;
      skid_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      id_pc_q      <= id_pc_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // redirect_trap only steers state when the trap feature is built in.
  logic unused_ok;
  assign unused_ok = redirect_trap;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch (RESET_PC = 0x100). Per-cycle vectors hold
// hand-derived expectations; each is pushed to a scoreboard queue when driven
// and popped and compared one clock later. Honors MISALIGN_TRAP_EN if defined.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_misaligned;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ipc;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  // Memory contents: a distinct word per address, never equal to NOP here.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC3A5_0000;
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rdata        (imem_rdata),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid)
`ifdef MISALIGN_TRAP_EN
    ,
    .fetch_misaligned  (fetch_misaligned)
`endif
  );

`ifndef MISALIGN_TRAP_EN
  assign fetch_misaligned = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic b, input logic [31:0] t, input logic r,
                     input logic ereq, input logic [31:0] eaddr, input logic ev,
                     input logic [31:0] eipc, input logic emis);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.rdy = r;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = ev; v.exp_ipc = eipc; v.exp_mis = emis;
    vecs.push_back(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h100);
    check({tag, "_valid"}, {31'b0, if_id_valid}, 32'd0);
    check({tag, "_instr"}, if_id_instruction, NOP);
    check({tag, "_pc"}, if_id_pc, 32'h0);
    check({tag, "_pc4"}, if_id_pc_plus4, 32'h4);
    check({tag, "_mis"}, {31'b0, fetch_misaligned}, 32'd0);
  endtask

  initial begin
    exp_t e;
    string nm;

    //  stall br  target        rdy  req  addr          valid ipc          mis
    add(0, 0, 32'h0,        1,  1, 32'h100,      0, 32'h0,        0); // BOOT -> FETCH
    add(0, 0, 32'h0,        1,  1, 32'h104,      1, 32'h100,      0);
    add(0, 0, 32'h0,        1,  1, 32'h108,      1, 32'h104,      0);
    add(0, 0, 32'h0,        1,  1, 32'h10C,      1, 32'h108,      0);
    add(0, 1, 32'h0,        1,  1, 32'h0,        0, 32'h0,        0); // redirect to 0
    add(0, 0, 32'h0,        1,  1, 32'h4,        1, 32'h0,        0);
    add(0, 0, 32'h0,        1,  1, 32'h8,        1, 32'h4,        0);
    add(0, 0, 32'h0,        0,  1, 32'h8,        0, 32'h0,        0); // wait state 1
    add(0, 0, 32'h0,        0,  1, 32'h8,        0, 32'h0,        0); // wait state 2
    add(0, 0, 32'h0,        1,  1, 32'hC,        1, 32'h8,        0);
    add(0, 0, 32'h0,        1,  1, 32'h10,       1, 32'hC,        0);
    add(1, 0, 32'h0,        1,  0, 32'h14,       1, 32'hC,        0); // 0x10 into skid
    add(1, 0, 32'h0,        1,  0, 32'h14,       1, 32'hC,        0);
    add(1, 0, 32'h0,        1,  0, 32'h14,       1, 32'hC,        0);
    add(0, 0, 32'h0,        1,  1, 32'h14,       1, 32'h10,       0); // skid drains
    add(0, 0, 32'h0,        1,  1, 32'h18,       1, 32'h14,       0);
    add(1, 1, 32'h200,      1,  1, 32'h200,      0, 32'h0,        0); // redirect beats stall
    add(0, 0, 32'h0,        1,  1, 32'h204,      1, 32'h200,      0);
    add(0, 1, 32'hFFFFFFFC, 1,  1, 32'hFFFFFFFC, 0, 32'h0,        0);
    add(0, 0, 32'h0,        1,  1, 32'h0,        1, 32'hFFFFFFFC, 0); // PC wraps
    add(0, 0, 32'h0,        1,  1, 32'h4,        1, 32'h0,        0);
    add(1, 0, 32'h0,        0,  1, 32'h4,        1, 32'h0,        0); // stall, no completion
    add(0, 0, 32'h0,        1,  1, 32'h8,        1, 32'h4,        0);
    add(1, 0, 32'h0,        1,  0, 32'hC,        1, 32'h4,        0); // into HOLD
    add(1, 1, 32'h40,       1,  1, 32'h40,       0, 32'h0,        0); // redirect from HOLD
    add(0, 0, 32'h0,        1,  1, 32'h44,       1, 32'h40,       0);
`ifdef MISALIGN_TRAP_EN
    add(0, 1, 32'h202,      1,  0, 32'h202,      0, 32'h0,        1); // trap
    add(0, 1, 32'h300,      1,  0, 32'h202,      0, 32'h0,        1); // frozen
`else
    add(0, 1, 32'h202,      1,  1, 32'h200,      0, 32'h0,        0); // aligned down
    add(0, 0, 32'h0,        1,  1, 32'h204,      1, 32'h200,      0);
`endif

    // Reset asserted from time zero.
    #12;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    check("boot_req", {31'b0, imem_req}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt; imem_ready = vecs[i].rdy;
      e.req = vecs[i].exp_req; e.addr = vecs[i].exp_addr; e.valid = vecs[i].exp_valid;
      e.ipc = vecs[i].exp_ipc; e.mis = vecs[i].exp_mis;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      nm = $sformatf("v%0d", i);
      check({nm, "_req"}, {31'b0, imem_req}, {31'b0, e.req});
      check({nm, "_addr"}, imem_addr, e.addr);
      check({nm, "_valid"}, {31'b0, if_id_valid}, {31'b0, e.valid});
      check({nm, "_mis"}, {31'b0, fetch_misaligned}, {31'b0, e.mis});
      if (e.valid) begin
        check({nm, "_instr"}, if_id_instruction, instr_of(e.ipc));
        check({nm, "_pc"}, if_id_pc, e.ipc);
        check({nm, "_pc4"}, if_id_pc_plus4, e.ipc + 32'd4);
      end else begin
        check({nm, "_instr"}, if_id_instruction, NOP);
      end
      $display("vec %0d: stall=%0b br=%0b rdy=%0b -> req=%0b addr=%08h valid=%0b pc=%08h instr=%08h",
               i, stall, branch_taken, imem_ready, imem_req, imem_addr, if_id_valid,
               if_id_pc, if_id_instruction);
    end

    // Reset in the middle of a cycle with a completing access pending.
    stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
`ifdef MISALIGN_TRAP_EN
    check("trap_req", {31'b0, imem_req}, 32'd0);
`else
    check("pre_rst_req", {31'b0, imem_req}, 32'd1);
`endif
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    @(posedge clk); #1;
    check_reset_outputs("held");
    reset = 1'b0;
    @(posedge clk); #1;
    check("rel_req", {31'b0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'h100);
    check("rel_valid", {31'b0, if_id_valid}, 32'd0);
    @(posedge clk); #1;
    check("rel2_valid", {31'b0, if_id_valid}, 32'd1);
    check("rel2_pc", if_id_pc, 32'h100);
    check("rel2_instr", if_id_instruction, instr_of(32'h100));
    $display("reset sequence: req=%0b addr=%08h valid=%0b pc=%08h",
             imem_req, imem_addr, if_id_valid, if_id_pc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hazard unit: hold IF/ID contents, no new instruction issued to decode.
REQ-005 branch_taken  input  1  EX-stage redirect request; priority over everything but reset.
REQ-006 branch_target  input  32  redirect address.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  fetch address, equals internal PC.
REQ-009 imem_ready  input  1  access completes in a cycle where imem_req && imem_ready.
REQ-010 imem_rdata  input  32  instruction word, valid when access completes.
REQ-011 if_id_instruction  output  32  registered instruction to control unit and decoder.
REQ-012 if_id_pc  output  32  registered address of if_id_instruction.
REQ-013 if_id_pc_plus4  output  32  if_id_pc + 4, for JAL/JALR link.
REQ-014 if_id_valid  output  1  if_id_instruction is a real instruction.
REQ-015 fetch_misaligned  output  1  present only with MISALIGN_TRAP_EN.

Function
REQ-016 FSM states: BOOT, FETCH, HOLD; plus TRAP with MISALIGN_TRAP_EN.
REQ-017 BOOT: imem_req=0; unconditionally to FETCH next cycle.
REQ-018 FETCH: imem_req=1, imem_addr=PC, stable until completion or redirect.
REQ-019 FETCH, complete, !stall: IF/ID <= {imem_rdata, PC, PC+4}, valid=1, PC <= PC+4, stay FETCH.
REQ-020 FETCH, complete, stall: skid buffer <= {imem_rdata, PC}, PC <= PC+4, go HOLD; IF/ID unchanged.
REQ-021 FETCH, not complete, !stall: if_id_valid <= 0, if_id_instruction <= 32'h00000013 (NOP); PC held.
REQ-022 FETCH, not complete, stall: IF/ID and PC unchanged.
REQ-023 HOLD: imem_req=0; when !stall, IF/ID <= skid buffer with valid=1, go FETCH; else remain.
REQ-024 branch_taken in any non-TRAP state: PC <= target, IF/ID <= NOP with valid=0, skid buffer discarded, go FETCH; same-cycle completing imem_rdata discarded; stall ignored.
REQ-025 PC arithmetic modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.
REQ-026 Latency: instruction from a completing access visible on IF/ID outputs the next cycle.
REQ-027 At most one outstanding request; no request in BOOT, HOLD, TRAP.

Reset
REQ-028 Reset asserted asynchronously: state BOOT, PC=RESET_PC, imem_req=0, if_id_instruction=32'h00000013, if_id_pc=0, if_id_pc_plus4=4, if_id_valid=0, skid buffer cleared, fetch_misaligned=0.
REQ-029 Reset mid-access abandons the request; completing data that cycle ignored.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN.
REQ-031 Defined: branch_taken with branch_target[1:0]!=0 loads PC with target, flushes IF/ID, enters TRAP; TRAP: imem_req=0, fetch_misaligned=1, outputs frozen until reset.
REQ-032 Undefined: branch_target[1:0] forced to 2'b00 before loading PC; no TRAP state, no fetch_misaligned port.

Verification
REQ-033 Reset with RESET_PC=0x100, imem_ready=1 always -> BOOT one cycle, then IF/ID pc 0x100, 0x104, 0x108 on consecutive cycles, valid=1.
REQ-034 imem_ready low 2 cycles at PC 0x8 -> imem_addr held 0x8, two NOP bubbles (valid=0), then instruction of 0x8.
REQ-035 stall asserted as 0x10 access completes, held 3 cycles -> IF/ID keeps 0xC word, imem_req=0 in HOLD, 0x10 appears after stall drops, then 0x14 fetched.
REQ-036 branch_taken to 0x200 together with stall and completing access -> completing data dropped, NOP valid=0 next cycle, imem_addr=0x200.
REQ-037 PC 0xFFFFFFFC, imem_ready=1 -> next imem_addr 0x00000000, if_id_pc_plus4 0x00000000.
REQ-038 branch_target 0x202: with MISALIGN_TRAP_EN -> fetch_misaligned=1, imem_req=0 until reset; without -> imem_addr 0x200.
